// File: rtl/status_uart_tx.sv
// Serial status transmitter: sends a 6-byte frame (header, four status bytes, XOR checksum)
// as 8N1, LSB first, with the bytes sent back-to-back.
module status_uart_tx #(
   parameter int         CLKS_PER_BIT = 10416,
   parameter logic [7:0] HEADER       = 8'hA5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        send,
   input  logic [31:0] frame,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] baudCnt;
   logic [2:0]    bitIdx;
   logic [2:0]    byteIdx;
   logic [31:0]   frameReg;
   logic [7:0]    chkReg;
   logic [7:0]    curByte;
   logic          baudDone;

   assign baudDone = (baudCnt == BAUD_LAST);

   always_comb begin
      curByte = HEADER;
      case (byteIdx)
         3'd1:    curByte = frameReg[31:24];
         3'd2:    curByte = frameReg[23:16];
         3'd3:    curByte = frameReg[15:8];
         3'd4:    curByte = frameReg[7:0];
         3'd5:    curByte = chkReg;
         default: curByte = HEADER;
      endcase
   end

   // tx is updated one cycle ahead at each bit boundary so the line itself is a flop output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         byteIdx  <= '0;
         frameReg <= '0;
         chkReg   <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (send) begin
                  frameReg <= frame;
                  chkReg   <= frame[31:24] ^ frame[23:16] ^ frame[15:8] ^ frame[7:0];
                  byteIdx  <= '0;
                  bitIdx   <= '0;
                  baudCnt  <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  tx      <= curByte[0];
                  state   <= DATA;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (bitIdx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx <= bitIdx + 3'd1;
                     tx     <= curByte[bitIdx + 3'd1];
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (byteIdx < 3'd5) begin
                     byteIdx <= byteIdx + 3'd1;
                     tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     byteIdx <= '0;
                     tx      <= 1'b1;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_status_uart_tx.sv
// Self-checking bench for status_uart_tx: a frame-level model queues expected bytes and
// timing, while a line decoder and per-cycle monitor compare against the DUT.
module tb_status_uart_tx;

   localparam int         CPB          = 4;
   localparam logic [7:0] HDR          = 8'hA5;
   localparam int         FRAME_CYCLES = 60 * CPB;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        send;
   logic [31:0] frame;
   logic        tx;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   int cyc        = 0;
   int lastAccept = -100000;
   int nextFree   = 0;
   logic [7:0] byteQ[$];

   int         phase = 0;
   int         cnt;
   int         bitPos;
   logic       cur;
   logic       stable;
   logic [9:0] bits;
   logic [7:0] expByte;
   logic       expBusy;
   logic       expDone;

   status_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .HEADER      (HDR)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .send   (send),
      .frame  (frame),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   // Frame-level model: an accepted request owns the line for 240 cycles, then done, then idle
   always @(posedge clk) begin
      cyc++;
      if (reset_n === 1'b1 && send === 1'b1 && cyc >= nextFree) begin
         lastAccept = cyc;
         nextFree   = cyc + FRAME_CYCLES + 1;
         byteQ.push_back(HDR);
         for (int i = 3; i >= 0; i--) byteQ.push_back(frame[i*8 +: 8]);
         byteQ.push_back(frame[31:24] ^ frame[23:16] ^ frame[15:8] ^ frame[7:0]);
      end
   end

   always @(negedge reset_n) begin
      byteQ.delete();
      lastAccept = -100000;
      nextFree   = 0;
   end

   // Monitor: status timing every cycle, plus a UART decoder that insists every bit is steady for CPB samples
   always @(negedge clk) begin
      expBusy = (cyc >= lastAccept) && (cyc <= lastAccept + FRAME_CYCLES - 1);
      expDone = (cyc == lastAccept + FRAME_CYCLES);
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      if (!expBusy) checkOutput("txIdle", {31'd0, tx}, 32'd1);

      if (reset_n !== 1'b1) begin
         phase = 0;
      end else if (phase == 0) begin
         if (tx === 1'b0) begin
            phase  = 1;
            cnt    = 1;
            bitPos = 0;
            cur    = 1'b0;
            stable = 1'b1;
         end
      end else begin
         if (cnt == 0) cur = tx;
         else if (tx !== cur) stable = 1'b0;
         cnt++;
         if (cnt == CPB) begin
            bits[bitPos] = cur;
            cnt = 0;
            bitPos++;
            if (bitPos == 10) begin
               phase = 0;
               if (byteQ.size() == 0) begin
                  checkOutput("unexpectedByte", byteQ.size(), 32'd1);
               end else begin
                  expByte = byteQ.pop_front();
                  checkOutput("byte", {22'd0, stable, bits[9], bits[8:1]}, {22'd0, 2'b11, expByte});
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] f, input int holdCycles);
      @(negedge clk);
      frame = f;
      send  = 1'b1;
      repeat (holdCycles) @(negedge clk);
      send  = 1'b0;
   endtask

   task automatic waitIdle();
      bit finished = 1'b0;
      for (int i = 0; i < 800 && !finished; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && byteQ.size() == 0 && cyc > lastAccept + FRAME_CYCLES) finished = 1'b1;
      end
      if (!finished) checkOutput("waitIdleTimeout", 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b1;
      send    = 1'b0;
      frame   = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetTx", {31'd0, tx}, 32'd1);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(32'h12345678, 1);
      waitIdle();

      applyStimulus(32'h00000000, 1);
      waitIdle();

      applyStimulus(32'h12345678, 1);
      frame = 32'hFFFFFFFF;
      waitIdle();

      applyStimulus(32'hCAFE0123, 1);
      repeat (49) @(negedge clk);
      applyStimulus(32'hDEADBEEF, 1);
      waitIdle();

      applyStimulus(32'h0F1E2D3C, 2 * (FRAME_CYCLES + 1));
      waitIdle();

      applyStimulus(32'h89ABCDEF, 1);
      repeat (98) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midResetTx", {31'd0, tx}, 32'd1);
      checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
      checkOutput("midResetDone", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(32'h5A5AC3C3, 1);
      waitIdle();

      for (int n = 0; n < 8; n++) begin
         applyStimulus($urandom, $urandom_range(1, 3));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(10, 200)) @(negedge clk);
            applyStimulus($urandom, 1);
         end
         waitIdle();
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      checkOutput("leftoverBytes", byteQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
